// File: rtl/ro_meas_pkg.sv
// Shared definitions for the ring-oscillator frequency measurement block:
// FSM state encoding and default operand widths.
package ro_meas_pkg;

  localparam int DEF_CNT_W  = 24;
  localparam int DEF_GATE_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_GATE = 2'd2,
    ST_DONE = 2'd3
  } meas_state_t;

endpackage

// File: rtl/ro_freq_counter_if.sv
// Control/result bundle between the readout master and the frequency counter.
interface ro_freq_counter_if
  import ro_meas_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int GATE_W = DEF_GATE_W
) ();

  logic              start;
  logic              abort;
  logic [GATE_W-1:0] gate_len;
  logic              busy;
  logic [CNT_W-1:0]  result;
  logic              result_valid;
  logic              overflow;

  modport master (
    output start, abort, gate_len,
    input  busy, result, result_valid, overflow
  );

  modport slave (
    input  start, abort, gate_len,
    output busy, result, result_valid, overflow
  );

endinterface

// File: rtl/ro_edge_sync.sv
// Brings the asynchronous ring-oscillator output into the clock domain and
// flags each rising edge of the synchronized signal for one cycle.
module ro_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ro_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], ro_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/ro_freq_counter.sv
// Gated edge counter: counts rising edges of a ring oscillator over a
// programmable number of system-clock cycles and reports the saturated count.
module ro_freq_counter
  import ro_meas_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int GATE_W      = DEF_GATE_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n,
  input  logic               ro_in,
  ro_freq_counter_if.slave   bus
);

  logic [1:0]        rst_sync_reg;
  logic              rst_int_n;
  logic              rise;

  meas_state_t       state_reg, state_next;
  logic [GATE_W-1:0] timer_reg, timer_next;
  logic [GATE_W-1:0] gate_len_reg, gate_len_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CNT_W-1:0]  result_reg, result_next;
  logic              valid_reg, valid_next;
  logic              ovf_reg, ovf_next;

  // Reset asserts immediately but releases two clock edges after wb_rst_n rises.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) rst_sync_reg <= 2'b00;
    else           rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_int_n = rst_sync_reg[1];

  ro_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk   (wb_clk_i),
    .rst_n (rst_int_n),
    .ro_in (ro_in),
    .rise  (rise)
  );

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    gate_len_next = gate_len_reg;
    cnt_next      = cnt_reg;
    result_next   = result_reg;
    valid_next    = 1'b0;
    ovf_next      = ovf_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          gate_len_next = bus.gate_len;
          cnt_next      = '0;
          ovf_next      = 1'b0;
          timer_next    = '0;
          state_next    = ST_ARM;
        end
      end
      ST_ARM: begin
        // Edges seen here may predate the window, so the synchronizer is only flushed.
        if (bus.abort) begin
          state_next = ST_IDLE;
        end else if (timer_reg == GATE_W'(SYNC_STAGES)) begin
          timer_next = '0;
          state_next = (gate_len_reg == '0) ? ST_DONE : ST_GATE;
        end else begin
          timer_next = timer_reg + GATE_W'(1);
        end
      end
      ST_GATE: begin
        if (bus.abort) begin
          state_next = ST_IDLE;
        end else begin
          if (rise) begin
            if (cnt_reg == '1) ovf_next = 1'b1;
            else               cnt_next = cnt_reg + CNT_W'(1);
          end
          if (timer_reg == gate_len_reg - GATE_W'(1)) state_next = ST_DONE;
          else                                        timer_next = timer_reg + GATE_W'(1);
        end
      end
      ST_DONE: begin
        result_next = cnt_reg;
        valid_next  = 1'b1;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_reg    <= ST_IDLE;
      timer_reg    <= '0;
      gate_len_reg <= '0;
      cnt_reg      <= '0;
      result_reg   <= '0;
      valid_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      gate_len_reg <= gate_len_next;
      cnt_reg      <= cnt_next;
      result_reg   <= result_next;
      valid_reg    <= valid_next;
      ovf_reg      <= ovf_next;
    end
  end

  assign bus.busy         = (state_reg != ST_IDLE);
  assign bus.result       = result_reg;
  assign bus.result_valid = valid_reg;
  assign bus.overflow     = ovf_reg;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Randomized bench for ro_freq_counter: the expected count is derived from the
// recorded ro_in waveform over the gate window, plus directed corner cases.
module tb_ro_freq_counter;
  import ro_meas_pkg::*;

  localparam int CNT_W  = 24;
  localparam int GATE_W = 20;
  localparam int SS     = 2;

  logic wb_clk_i = 1'b0;
  logic wb_rst_n = 1'b0;
  logic ro_in    = 1'b0;

  always #5 wb_clk_i = ~wb_clk_i;

  ro_freq_counter_if #(.CNT_W(CNT_W), .GATE_W(GATE_W)) bus ();
  ro_freq_counter_if #(.CNT_W(4),     .GATE_W(GATE_W)) bus4 ();

  ro_freq_counter #(.CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(SS)) u_dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_n (wb_rst_n),
    .ro_in    (ro_in),
    .bus      (bus)
  );

  ro_freq_counter #(.CNT_W(4), .GATE_W(GATE_W), .SYNC_STAGES(SS)) u_dut4 (
    .wb_clk_i (wb_clk_i),
    .wb_rst_n (wb_rst_n),
    .ro_in    (ro_in),
    .bus      (bus4)
  );

  int     n_vec = 0;
  int     n_err = 0;
  int     cyc = 0;
  bit     hist [0:65535];
  int     ro_mode = 0;
  int     ro_per = 8;
  int     ph = 0;
  longint last_result = 0;

  // hist[k] is the ro_in level sampled by rising clock edge k
  initial forever begin
    @(posedge wb_clk_i);
    cyc++;
    hist[cyc] = ro_in;
  end

  initial forever begin
    @(negedge wb_clk_i);
    if (ro_mode == 0) begin
      ph    = (ph + 1) % ro_per;
      ro_in = (ph < ro_per / 2);
    end else begin
      ro_in = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Rising edges seen in the sampled waveform between edges a and b inclusive
  function automatic longint rises(input int a, input int b);
    longint n = 0;
    for (int j = a; j <= b; j++)
      if (hist[j] && !hist[j-1]) n++;
    return n;
  endfunction

  // One full measurement; optionally re-pulses start mid-run with mid_gl
  task automatic measure(input int gl, input int mid_gl, output longint got);
    int     t0, tv, nb;
    bit     seen;
    longint exp;
    got = 0;
    @(negedge wb_clk_i);
    bus.start    = 1'b1;
    bus.gate_len = GATE_W'(gl);
    @(posedge wb_clk_i); #1;
    t0 = cyc;
    @(negedge wb_clk_i);
    bus.start = 1'b0;
    nb = 0; seen = 1'b0; tv = 0;
    for (int i = 0; i < gl + 20 && !seen; i++) begin
      if (bus.result_valid) begin
        seen = 1'b1;
        tv   = cyc;
      end else begin
        if (bus.busy) nb++;
        bus.start = (mid_gl != 0 && i == gl / 2);
        if (bus.start) bus.gate_len = GATE_W'(mid_gl);
        @(negedge wb_clk_i);
      end
    end
    bus.start = 1'b0;
    chk("valid_timeout", longint'(seen), 1);
    if (seen) begin
      exp = rises(t0 + 2, t0 + gl + 1);
      got = longint'(bus.result);
      $display("meas gate_len=%0d mode=%0d per=%0d result=%0d model=%0d latency=%0d",
               gl, ro_mode, ro_per, got, exp, tv - t0);
      chk("latency", tv - t0, gl + SS + 2);
      chk("result", got, exp);
      chk("busy_len", nb, gl + SS + 2);
      chk("busy_off", longint'(bus.busy), 0);
      chk("overflow", longint'(bus.overflow), 0);
      @(negedge wb_clk_i);
      chk("single_pulse", longint'(bus.result_valid), 0);
      chk("result_hold", longint'(bus.result), exp);
      last_result = exp;
    end
  endtask

  initial begin
    int     t0, nv, gl;
    bit     seen;
    longint r, exp;

    bus.start = 1'b0; bus.abort = 1'b0; bus.gate_len = '0;
    bus4.start = 1'b0; bus4.abort = 1'b0; bus4.gate_len = '0;

    // Reset state
    repeat (3) @(negedge wb_clk_i);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_valid", longint'(bus.result_valid), 0);
    chk("rst_result", longint'(bus.result), 0);
    chk("rst_ovf", longint'(bus.overflow), 0);

    // Start on the second edge after release is still inside the reset window
    wb_rst_n = 1'b1;
    @(negedge wb_clk_i);
    bus.start = 1'b1; bus.gate_len = GATE_W'(5);
    @(negedge wb_clk_i);
    bus.start = 1'b0;
    chk("early_start_ignored", longint'(bus.busy), 0);

    // Square wave, period 8, 800-cycle gate
    ro_mode = 0; ro_per = 8;
    measure(800, 0, r);
    chk("p8_in_range", longint'(r >= 99 && r <= 101), 1);

    // Zero-length gate
    measure(0, 0, r);
    chk("zero_gate_result", r, 0);

    // Randomized waveforms and gate lengths
    for (int k = 0; k < 8; k++) begin
      ro_mode = int'($urandom_range(0, 1));
      ro_per  = int'($urandom_range(2, 16));
      gl      = int'($urandom_range(1, 250));
      measure(gl, 0, r);
    end

    // Restart attempt with a different gate_len in the middle of GATE
    ro_mode = 0; ro_per = 6;
    measure(300, 50, r);

    // Abort on the 50th GATE cycle
    ro_mode = 1;
    @(negedge wb_clk_i);
    bus.start = 1'b1; bus.gate_len = GATE_W'(200);
    @(posedge wb_clk_i); #1;
    t0 = cyc;
    @(negedge wb_clk_i);
    bus.start = 1'b0;
    chk("abort_armed", longint'(bus.busy), 1);
    for (int i = 0; i < 100 && cyc < t0 + SS + 50; i++) @(negedge wb_clk_i);
    bus.abort = 1'b1;
    @(negedge wb_clk_i);
    bus.abort = 1'b0;
    chk("abort_busy", longint'(bus.busy), 0);
    nv = 0;
    repeat (250) begin
      if (bus.result_valid) nv++;
      @(negedge wb_clk_i);
    end
    chk("abort_no_valid", nv, 0);
    chk("abort_result", longint'(bus.result), last_result);
    chk("abort_ovf", longint'(bus.overflow), 0);
    $display("abort at GATE cycle 50: busy=%0d valids=%0d result=%0d", bus.busy, nv, bus.result);

    // Abort and start together in IDLE: start dropped
    bus.start = 1'b1; bus.abort = 1'b1; bus.gate_len = GATE_W'(7);
    @(negedge wb_clk_i);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("abort_start_idle", longint'(bus.busy), 0);

    // 4-bit counter saturation, then the next start clears overflow
    ro_mode = 0; ro_per = 4;
    @(negedge wb_clk_i);
    bus4.start = 1'b1; bus4.gate_len = GATE_W'(100);
    @(posedge wb_clk_i); #1;
    t0 = cyc;
    @(negedge wb_clk_i);
    bus4.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 140 && !seen; i++) begin
      if (bus4.result_valid) seen = 1'b1;
      else @(negedge wb_clk_i);
    end
    chk("sat_timeout", longint'(seen), 1);
    exp = rises(t0 + 2, t0 + 101);
    chk("sat_result", longint'(bus4.result), (exp > 15) ? 15 : exp);
    chk("sat_ovf", longint'(bus4.overflow), longint'(exp > 15));
    $display("sat cnt_w=4 edges=%0d result=%0d overflow=%0d", exp, bus4.result, bus4.overflow);
    @(negedge wb_clk_i);
    bus4.start = 1'b1; bus4.gate_len = GATE_W'(4);
    @(negedge wb_clk_i);
    bus4.start = 1'b0;
    chk("ovf_cleared", longint'(bus4.overflow), 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus4.result_valid) seen = 1'b1;
      else @(negedge wb_clk_i);
    end
    chk("sat2_timeout", longint'(seen), 1);

    // Reset pulse in the middle of GATE
    ro_mode = 1;
    @(negedge wb_clk_i);
    bus.start = 1'b1; bus.gate_len = GATE_W'(300);
    @(negedge wb_clk_i);
    bus.start = 1'b0;
    repeat (100) @(negedge wb_clk_i);
    wb_rst_n = 1'b0;
    #1;
    chk("midrst_busy", longint'(bus.busy), 0);
    chk("midrst_valid", longint'(bus.result_valid), 0);
    chk("midrst_result", longint'(bus.result), 0);
    chk("midrst_ovf", longint'(bus.overflow), 0);
    $display("reset mid-GATE: busy=%0d result=%0d", bus.busy, bus.result);
    repeat (3) @(negedge wb_clk_i);
    wb_rst_n = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    measure(int'($urandom_range(20, 200)), 0, r);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
